// File: rtl/fifo_wr_arbiter.sv
// Round-robin write scheduler sharing one async-FIFO write port between a
// single-beat requester (0) and a two-beat requester (1); frames are atomic.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic                    req0,
  input  logic [DATA_WIDTH-1:0]   data0,
  input  logic                    req1,
  input  logic [2*DATA_WIDTH-1:0] data1,
  input  logic                    wfull,
  output logic                    winc,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    ack0,
  output logic                    ack1,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  typedef struct packed {
    logic                    owner;
    logic [2*DATA_WIDTH-1:0] data;
  } frame_t;

  state_t                  state_q, state_d;
  frame_t                  cap_q, cap_d;
  logic                    last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    ack0_q, ack0_d;
  logic                    ack1_q, ack1_d;
  logic                    elig0, elig1, gnt_vld, gnt;

  assign winc    = (state_q != IDLE) && !wfull;
  assign busy    = (state_q != IDLE);
  assign wr_data = wr_data_q;
  assign ack0    = ack0_q;
  assign ack1    = ack1_q;

  // A requester whose ack is showing this cycle is still holding req from the
  // frame just finished, so it is masked out to prevent a retrigger.
  always_comb begin
    elig0   = req0 && !ack0_q;
    elig1   = req1 && !ack1_q;
    gnt_vld = elig0 || elig1;
    gnt     = (elig0 && elig1) ? !last_grant_q : elig1;
  end

  always_comb begin
    state_d      = state_q;
    cap_d        = cap_q;
    last_grant_d = last_grant_q;
    wr_data_d    = wr_data_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d      = BEAT0;
          last_grant_d = gnt;
          cap_d.owner  = gnt;
          cap_d.data   = gnt ? data1 : {{DATA_WIDTH{1'b0}}, data0};
          wr_data_d    = cap_d.data[DATA_WIDTH-1:0];
        end
      end
      BEAT0: begin
        if (winc) begin
          if (cap_q.owner) begin
            state_d   = BEAT1;
            wr_data_d = cap_q.data[2*DATA_WIDTH-1:DATA_WIDTH];
          end else begin
            state_d = IDLE;
            ack0_d  = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (winc) begin
          state_d = IDLE;
          ack1_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q      <= IDLE;
      cap_q        <= '0;
      last_grant_q <= 1'b1;
      wr_data_q    <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cap_q        <= cap_d;
      last_grant_q <= last_grant_d;
      wr_data_q    <= wr_data_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench: a frame-level reference model queues the expected FIFO
// beats at grant time; a negedge monitor pops and compares every write.
module tb_fifo_wr_arbiter;
  localparam int W = 8;

  logic         wclk = 1'b0;
  logic         wrst_n;
  logic         req0, req1, wfull;
  logic [W-1:0] data0;
  logic [2*W-1:0] data1;
  logic         winc, ack0, ack1, busy;
  logic [W-1:0] wr_data;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(.DATA_WIDTH(W)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req0(req0), .data0(data0),
    .req1(req1), .data1(data1), .wfull(wfull), .winc(winc),
    .wr_data(wr_data), .ack0(ack0), .ack1(ack1), .busy(busy)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks which requester owns the port, how many beats of
  // the current frame remain, and who was granted last.
  logic [W-1:0] expq[$];
  int  grant_log[$];
  bit  m_busy, m_last, m_owner, m_ack0, m_ack1;
  int  m_left;

  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      m_busy = 0; m_last = 1; m_owner = 0; m_left = 0;
      m_ack0 = 0; m_ack1 = 0;
      expq.delete();
    end else begin
      bit n0, n1, p0, p1;
      n0 = 0; n1 = 0;
      if (!m_busy) begin
        p0 = req0 && !m_ack0;
        p1 = req1 && !m_ack1;
        if (p0 || p1) begin
          m_owner = (p0 && p1) ? !m_last : p1;
          m_last  = m_owner;
          m_busy  = 1;
          grant_log.push_back(int'(m_owner));
          if (m_owner) begin
            expq.push_back(data1[W-1:0]);
            expq.push_back(data1[2*W-1:W]);
            m_left = 2;
          end else begin
            expq.push_back(data0);
            m_left = 1;
          end
        end
      end else if (!wfull) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          if (m_owner) n1 = 1; else n0 = 1;
        end
      end
      m_ack0 = n0;
      m_ack1 = n1;
    end
  end

  // Monitor
  always @(negedge wclk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("ack0", 32'(ack0), 32'(m_ack0));
    chk("ack1", 32'(ack1), 32'(m_ack1));
    chk("winc", 32'(winc), 32'(m_busy && !wfull && wrst_n));
    if (winc) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_unexpected: got write %0h with empty scoreboard", wr_data);
      end else begin
        logic [W-1:0] e;
        e = expq.pop_front();
        chk("wr_data", 32'(wr_data), 32'(e));
      end
    end
  end

  task automatic cyc();
    @(posedge wclk); #2;
  endtask

  task automatic wait_ack(input int which);
    int n = 0;
    while (!(which ? ack1 : ack0) && n < 60) begin cyc(); n++; end
    checks++;
    if (!(which ? ack1 : ack0)) begin
      errors++;
      $display("FAIL ack_timeout: ack%0d not seen, got 0 expected 1", which);
    end
  endtask

  initial begin
    wrst_n = 0; req0 = 0; req1 = 0; wfull = 0; data0 = '0; data1 = '0;
    #1;
    chk("rst_winc", 32'(winc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_ack", 32'({ack0, ack1}), 0);
    #20;
    // Both requesters held from reset: expect grants 0,1,0,1
    req0 = 1; req1 = 1; data0 = 8'h11; data1 = 16'h3322;
    wrst_n = 1;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      cyc();
      while (!(ack0 || ack1) && n < 60) begin cyc(); n++; end
      data0 = data0 + 8'h44; data1 = data1 + 16'h4444;
    end
    req0 = 0; req1 = 0;
    chk("order_len", 32'(grant_log.size()), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      chk("order", 32'(grant_log[k]), 32'(k % 2));
    cyc(); cyc();

    // Single req0 0xA5; data changed after grant must not leak into the FIFO
    req0 = 1; data0 = 8'hA5;
    cyc();
    data0 = 8'hFF;
    chk("a5_winc", 32'(winc), 1);
    chk("a5_data", 32'(wr_data), 32'h A5);
    wait_ack(0);
    req0 = 0;
    cyc(); cyc();

    // Single req1 0x1234 with a 5-cycle wfull stall during the high beat
    req1 = 1; data1 = 16'h1234;
    cyc();
    cyc();
    wfull = 1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("stall_data", 32'(wr_data), 32'h12);
      chk("stall_winc", 32'(winc), 0);
    end
    wfull = 0;
    wait_ack(1);
    req1 = 0;
    cyc();

    // wfull already high at grant
    wfull = 1; req0 = 1; data0 = 8'h5A;
    cyc(); data0 = 8'h00;
    cyc(); cyc();
    wfull = 0;
    wait_ack(0);
    req0 = 0;
    cyc();

    // Reset during BEAT1, then both request: req0 must win the first tie
    req1 = 1; data1 = 16'hBEEF;
    cyc(); cyc();
    chk("pre_rst_busy", 32'(busy), 1);
    wrst_n = 0;
    #1;
    chk("mid_rst_winc", 32'(winc), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ack", 32'({ack0, ack1}), 0);
    req1 = 0;
    cyc();
    wrst_n = 1;
    grant_log.delete();
    req0 = 1; req1 = 1; data0 = 8'h77; data1 = 16'h9988;
    cyc();
    chk("post_rst_grant", 32'(grant_log.size() > 0 ? grant_log[0] : 9), 0);
    wait_ack(0);
    req0 = 0;
    wait_ack(1);
    req1 = 0;
    cyc();

    // Randomized traffic with random backpressure and data churn
    for (int t = 0; t < 3000; t++) begin
      @(posedge wclk); #2;
      if (req0) begin if (ack0) req0 = $urandom_range(0, 1); end
      else req0 = ($urandom_range(0, 2) == 0);
      if (req1) begin if (ack1) req1 = $urandom_range(0, 1); end
      else req1 = ($urandom_range(0, 2) == 0);
      data0 = W'($urandom);
      data1 = (2*W)'($urandom);
      wfull = ($urandom_range(0, 9) < 3);
    end
    req0 = 0; req1 = 0; wfull = 0;
    repeat (6) cyc();
    chk("drain", 32'(expq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
